// File: rtl/nn_axi_loader.sv
// AXI4-Lite initiator that drives the digit-recognition peripheral from fabric logic:
// optional magic check, pixel streaming with per-pixel counter writes, settle, result read.
module nn_axi_loader #(
  parameter logic [15:0] BASE_ADDR     = 16'h0000,
  parameter int unsigned NUM_PIXELS    = 784,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CHECK_MAGIC   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [23:0] result,
  output logic        m_axi_awvalid,
  output logic [15:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  input  logic        m_axi_awready,
  output logic        m_axi_wvalid,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  input  logic        m_axi_wready,
  input  logic        m_axi_bvalid,
  input  logic [1:0]  m_axi_bresp,
  output logic        m_axi_bready,
  output logic        m_axi_arvalid,
  output logic [15:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  input  logic        m_axi_arready,
  input  logic        m_axi_rvalid,
  input  logic [1:0]  m_axi_rresp,
  input  logic [31:0] m_axi_rdata,
  output logic        m_axi_rready
);

  localparam int unsigned IDX_W = $clog2(NUM_PIXELS + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [15:0] MAGIC_ADDR = BASE_ADDR + 16'h0008;
  localparam logic [15:0] PIX_ADDR   = BASE_ADDR + 16'h000C;
  localparam logic [15:0] CNT_ADDR   = BASE_ADDR + 16'h0010;
  localparam logic [15:0] RES_ADDR   = BASE_ADDR + 16'h0014;
  localparam logic [31:0] MAGIC_VAL  = 32'h4746_5550;

  typedef enum logic [3:0] {
    S_IDLE, S_MAG_AR, S_MAG_R, S_PIX, S_WR, S_WB, S_SETTLE, S_RES_AR, S_RES_R, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              target_q, target_d;   // 0: pixel register, 1: counter register
  logic              pix_ready_q, pix_ready_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [23:0]       result_q, result_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic [15:0]       awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0]       wdata_q, wdata_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settle_d    = settle_q;
    target_d    = target_q;
    pix_ready_d = pix_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    err_code_d  = err_code_q;
    result_d    = result_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    idx_inc     = idx_q + IDX_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          error_d    = 1'b0;
          err_code_d = 2'd0;
          idx_d      = '0;
          if (CHECK_MAGIC != 0) begin
            state_d   = S_MAG_AR;
            arvalid_d = 1'b1;
            araddr_d  = MAGIC_ADDR;
          end else begin
            state_d     = S_PIX;
            pix_ready_d = 1'b1;
          end
        end
      end
      S_MAG_AR, S_RES_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = (state_q == S_MAG_AR) ? S_MAG_R : S_RES_R;
        end
      end
      S_MAG_R: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          if (m_axi_rresp != 2'b00 || m_axi_rdata != MAGIC_VAL) begin
            error_d    = 1'b1;
            err_code_d = (m_axi_rresp != 2'b00) ? 2'd3 : 2'd1;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_FIN;
          end else begin
            pix_ready_d = 1'b1;
            state_d     = S_PIX;
          end
        end
      end
      S_PIX: begin
        if (pix_valid) begin
          pix_ready_d = 1'b0;
          target_d    = 1'b0;
          awvalid_d   = 1'b1;
          wvalid_d    = 1'b1;
          awaddr_d    = PIX_ADDR;
          wdata_d     = {8'h00, pix_data};
          state_d     = S_WR;
        end
      end
      S_WR: begin
        // Address and data channels retire independently; move on once both are done.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WB;
        end
      end
      S_WB: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp != 2'b00) begin
            error_d    = 1'b1;
            err_code_d = 2'd2;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = S_FIN;
          end else if (!target_q) begin
            target_d  = 1'b1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = CNT_ADDR;
            wdata_d   = 32'(idx_q);
            state_d   = S_WR;
          end else begin
            idx_d = idx_inc;
            if (idx_inc == IDX_W'(NUM_PIXELS)) begin
              settle_d = '0;
              state_d  = S_SETTLE;
            end else begin
              pix_ready_d = 1'b1;
              state_d     = S_PIX;
            end
          end
        end
      end
      S_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          arvalid_d = 1'b1;
          araddr_d  = RES_ADDR;
          state_d   = S_RES_AR;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_RES_R: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          if (m_axi_rresp != 2'b00) begin
            error_d    = 1'b1;
            err_code_d = 2'd3;
          end else begin
            result_d = m_axi_rdata[23:0];
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FIN;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      settle_q    <= '0;
      target_q    <= 1'b0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
      result_q    <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settle_q    <= settle_d;
      target_q    <= target_d;
      pix_ready_q <= pix_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      result_q    <= result_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign pix_ready     = pix_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_code      = err_code_q;
  assign result        = result_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_nn_axi_loader.sv
// Bench for nn_axi_loader: AXI4-Lite slave model with programmable ready delays and
// error injection, a table of job scenarios, and a mid-write reset sequence.
module tb_nn_axi_loader;

  localparam int NP     = 4;
  localparam int SETTLE = 5;
  localparam logic [31:0] MAGIC = 32'h4746_5550;

  logic        clk, reset, start, pix_valid, pix_ready, busy, done, error;
  logic [23:0] pix_data, result;
  logic [1:0]  err_code;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  nn_axi_loader #(.BASE_ADDR(16'h0000), .NUM_PIXELS(NP), .SETTLE_CYCLES(SETTLE), .CHECK_MAGIC(1)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .busy(busy), .done(done), .error(error), .err_code(err_code),
    .result(result),
    .m_axi_awvalid(awvalid), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awready(awready),
    .m_axi_wvalid(wvalid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wready(wready),
    .m_axi_bvalid(bvalid), .m_axi_bresp(bresp), .m_axi_bready(bready),
    .m_axi_arvalid(arvalid), .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arready(arready),
    .m_axi_rvalid(rvalid), .m_axi_rresp(rresp), .m_axi_rdata(rdata), .m_axi_rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [23:0] pv(input int j, input int k);
    return 24'(32'h00A5_0000 + j * 256 + k);
  endfunction

  // ---------------- slave model (acts on negedges, sees registered DUT outputs) ----------------
  int          aw_dly, w_dly, bad_wr, bad_rd;
  logic [31:0] slv_magic;
  logic [23:0] slv_res;
  logic [15:0] aw_log[$];
  logic [31:0] w_log[$];
  logic [15:0] ar_log[$];
  int          viol, cyc, last_b_cyc, ar_rise_cyc, n_wr;
  int          aw_cnt, w_cnt, ar_cnt;
  bit          aw_got, w_got;
  logic        p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
  logic [15:0] p_awaddr, p_araddr;
  logic [31:0] p_wdata;

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    cyc = 0; viol = 0; n_wr = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_got = 0; w_got = 0;
    {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
    p_awaddr = 0; p_araddr = 0; p_wdata = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_got = 0; w_got = 0;
        {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;
        continue;
      end
      // protocol rules on the master side
      if (p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) viol++;
      if (p_wv && !p_wr && (!wvalid || wdata != p_wdata)) viol++;
      if (p_arv && !p_arr && (!arvalid || araddr != p_araddr)) viol++;
      if (arvalid && (awvalid || wvalid || bready)) viol++;
      if ((awvalid || wvalid) && rready) viol++;
      if ((awvalid && awprot != 3'b000) || (arvalid && arprot != 3'b000)) viol++;
      if (wvalid && wstrb != 4'hF) viol++;
      if (arvalid && !p_arv) ar_rise_cyc = cyc;
      // handshakes that completed on the previous posedge
      if (p_bv && p_br) begin bvalid = 0; last_b_cyc = cyc; end
      if (p_rv && p_rr) rvalid = 0;
      if (p_awv && p_awr) begin aw_log.push_back(p_awaddr); aw_got = 1; end
      if (p_wv && p_wr) begin w_log.push_back(p_wdata); w_got = 1; end
      if (p_arv && p_arr) begin
        ar_log.push_back(p_araddr);
        rvalid = 1;
        rdata  = (p_araddr == 16'h0008) ? slv_magic : {8'hEE, slv_res};
        rresp  = ((bad_rd == 1 && p_araddr == 16'h0008) || (bad_rd == 2 && p_araddr == 16'h0014)) ? 2'b10 : 2'b00;
      end
      if (aw_got && w_got && !bvalid) begin
        bvalid = 1;
        bresp  = (n_wr == bad_wr) ? 2'b10 : 2'b00;
        n_wr++;
        aw_got = 0; w_got = 0;
      end
      // ready generation with programmable delay
      if (p_awv && p_awr) begin awready = 0; aw_cnt = 0; end
      else if (awvalid) begin if (aw_cnt >= aw_dly) awready = 1; else aw_cnt++; end
      else begin awready = 0; aw_cnt = 0; end
      if (p_wv && p_wr) begin wready = 0; w_cnt = 0; end
      else if (wvalid) begin if (w_cnt >= w_dly) wready = 1; else w_cnt++; end
      else begin wready = 0; w_cnt = 0; end
      if (p_arv && p_arr) begin arready = 0; ar_cnt = 0; end
      else if (arvalid) begin if (ar_cnt >= 1) arready = 1; else ar_cnt++; end
      else begin arready = 0; ar_cnt = 0; end
      p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
      p_bv = bvalid; p_br = bready; p_arv = arvalid; p_arr = arready;
      p_rv = rvalid; p_rr = rready;
      p_awaddr = awaddr; p_araddr = araddr; p_wdata = wdata;
    end
  end

  // ---------------- job scenarios ----------------
  typedef struct {
    logic [31:0] magic;
    int          aw_d, w_d, bad_w, bad_r, max_gap;
    bit          extra_start;
    logic [23:0] res_val;
    bit          exp_err;
    logic [1:0]  exp_code;
    int          exp_writes, exp_reads;
    logic [23:0] exp_result;
  } vec_t;

  vec_t vecs[8];

  task automatic set_slave(input vec_t v);
    slv_magic = v.magic; slv_res = v.res_val;
    aw_dly = v.aw_d; w_dly = v.w_d; bad_wr = v.bad_w; bad_rd = v.bad_r;
    aw_log.delete(); w_log.delete(); ar_log.delete();
    n_wr = 0; viol = 0; last_b_cyc = 0; ar_rise_cyc = 0;
  endtask

  task automatic run_job(input int vi);
    vec_t v;
    int   k, gap, ndone, lc, seq_err, nw;
    logic p_pr;
    bit   seen_done;
    v = vecs[vi];
    set_slave(v);
    k = 0; gap = 0; ndone = 0; lc = 0; p_pr = 0; seen_done = 0;
    pix_valid = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    chk($sformatf("v%0d_busy_after_start", vi), busy, 1);
    while (!seen_done && lc < 3000) begin
      if (pix_valid && p_pr) begin
        k++;
        pix_valid = 0;
        gap = (v.max_gap > 0) ? int'($urandom_range(v.max_gap, 0)) : 0;
      end
      if (!pix_valid && k < NP) begin
        if (gap == 0) begin pix_valid = 1; pix_data = pv(vi, k); end
        else gap--;
      end
      p_pr  = pix_ready;
      start = (v.extra_start && (lc % 7 == 3)) ? 1'b1 : 1'b0;
      @(negedge clk);
      lc++;
      if (done) begin
        ndone++;
        seen_done = 1;
        chk($sformatf("v%0d_busy_low_at_done", vi), busy, 0);
      end
    end
    start = 0;
    pix_valid = 0;
    chk($sformatf("v%0d_done_seen", vi), seen_done, 1);
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk($sformatf("v%0d_done_count", vi), ndone, 1);
    chk($sformatf("v%0d_busy_end", vi), busy, 0);
    chk($sformatf("v%0d_error", vi), error, v.exp_err);
    chk($sformatf("v%0d_err_code", vi), err_code, v.exp_code);
    chk($sformatf("v%0d_result", vi), result, v.exp_result);
    chk($sformatf("v%0d_aw_count", vi), aw_log.size(), v.exp_writes);
    chk($sformatf("v%0d_w_count", vi), w_log.size(), v.exp_writes);
    chk($sformatf("v%0d_ar_count", vi), ar_log.size(), v.exp_reads);
    chk($sformatf("v%0d_protocol", vi), viol, 0);
    seq_err = 0;
    nw = (aw_log.size() < w_log.size()) ? aw_log.size() : w_log.size();
    for (int i = 0; i < nw; i++) begin
      if (aw_log[i] != ((i % 2 == 0) ? 16'h000C : 16'h0010)) seq_err++;
      if (w_log[i] != ((i % 2 == 0) ? {8'h00, pv(vi, i / 2)} : 32'(i / 2))) seq_err++;
    end
    for (int i = 0; i < ar_log.size(); i++)
      if (ar_log[i] != ((i == 0) ? 16'h0008 : 16'h0014)) seq_err++;
    chk($sformatf("v%0d_sequence", vi), seq_err, 0);
    if (v.exp_reads == 2)
      chk($sformatf("v%0d_settle_gap", vi), ar_rise_cyc - last_b_cyc, SETTLE);
  endtask

  initial begin
    int lc;
    vecs[0] = '{MAGIC,        0, 0, -1, 0, 0, 0, 24'h000007, 0, 2'd0, 8, 2, 24'h000007};
    vecs[1] = '{32'h12345678, 0, 0, -1, 0, 0, 0, 24'h000007, 1, 2'd1, 0, 1, 24'h000007};
    vecs[2] = '{MAGIC,        0, 3, -1, 0, 0, 0, 24'h00ABCD, 0, 2'd0, 8, 2, 24'h00ABCD};
    vecs[3] = '{MAGIC,        3, 0, -1, 0, 0, 0, 24'h000123, 0, 2'd0, 8, 2, 24'h000123};
    vecs[4] = '{MAGIC,        2, 2, -1, 0, 0, 0, 24'h0F0F0F, 0, 2'd0, 8, 2, 24'h0F0F0F};
    vecs[5] = '{MAGIC,        0, 0,  2, 0, 0, 0, 24'h000AAA, 1, 2'd2, 3, 1, 24'h0F0F0F};
    vecs[6] = '{MAGIC,        1, 0, -1, 0, 5, 1, 24'h000055, 0, 2'd0, 8, 2, 24'h000055};
    vecs[7] = '{MAGIC,        0, 1, -1, 2, 0, 0, 24'h000999, 1, 2'd3, 8, 2, 24'h000055};

    reset = 1; start = 0; pix_valid = 0; pix_data = 0;
    set_slave(vecs[0]);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_result", result, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    reset = 0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_job(i);

    // reset while a pixel write is stalled with awvalid high
    set_slave(vecs[0]);
    aw_dly = 40; w_dly = 40;
    start = 1;
    @(negedge clk);
    start = 0;
    pix_valid = 1; pix_data = pv(9, 0);
    lc = 0;
    while (!awvalid && lc < 200) begin
      @(negedge clk);
      lc++;
    end
    pix_valid = 0;
    chk("rst_mid_wr_reached", awvalid, 1);
    reset = 1;
    @(negedge clk);
    chk("rst_mid_valids", {awvalid, wvalid, bready, arvalid, rready, pix_ready}, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_result", result, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    run_job(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nn_axi_loader.md
Name: nn_axi_loader

Overview:
- AXI4-Lite initiator that drives the digit-recognition peripheral's register map from fabric logic instead of the processor.
- Optionally checks the core magic, streams NUM_PIXELS pixels, waits a settle time, then reads back the prediction.
- Sits between a pixel source (camera or BRAM reader) and the peripheral's s_axi port.

Parameters:
- BASE_ADDR, 16'h0000, byte base address of the peripheral.
- NUM_PIXELS, 784, pixels per image.
- SETTLE_CYCLES, 16, idle cycles between the last pixel write and the result read (≥1).
- CHECK_MAGIC, 1, if 1, read and compare the magic register before streaming.

Ports:
- clk  in  1  single clock; also the AXI clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to process one image.
- pix_valid  in  1  pixel stream valid.
- pix_data  in  24  pixel value.
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of job (success or error).
- error  out  1  sticky until next accepted start.
- err_code  out  2  0 none, 1 bad magic, 2 write bresp≠OKAY, 3 read rresp≠OKAY.
- result  out  24  prediction from register 0x05 [23:0]; held until the next result.
- m_axi_awvalid/awaddr[15:0]/awprot[2:0]/awready, wvalid/wdata[31:0]/wstrb[3:0]/wready, bvalid/bresp[1:0]/bready, arvalid/araddr[15:0]/arprot[2:0]/arready, rvalid/rresp[1:0]/rdata[31:0]/rready  master side of AXI4-Lite.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Register byte addresses: BASE_ADDR + 4×word index, i.e. magic 0x08, pixel 0x0C, counter 0x10, result 0x14. Expected magic value is 32'h47465550.
- AXI constants: awprot = arprot = 3'b000 and wstrb = 4'hF.
- Reset values: all valid/ready outputs 0, busy 0, done 0, error 0, err_code 0, result 0, pix_ready 0. Addresses and wdata are 0 but don't-care.
- FSM states: IDLE, MAG_AR, MAG_R, PIX, WR, WB, SETTLE, RES_AR, RES_R, FIN.
- IDLE: start → busy=1, clear error/err_code, pixel index i=0, next state MAG_AR if CHECK_MAGIC else PIX. start is ignored in every other state.
- MAG_AR: arvalid=1, araddr=magic address; hold until arready.
- MAG_R: rready=1; on rvalid:
  - rresp≠0 → err 3, FIN;
  - rdata≠magic → err 1, FIN;
  - else PIX.
- PIX: pix_ready=1. On handshake, latch pix_data, go to WR with target = pixel register.
- WR: awvalid and wvalid assert together, with wdata = {8'h0, pixel} for the pixel register or i zero-extended for the counter register.
  - Each valid drops independently in the cycle after its own ready is seen. The address and data handshakes may complete in either order or the same cycle.
  - Move to WB once both are accepted.
- WB: bready=1; on bvalid:
  - bresp≠0 → err 2, FIN;
  - after the pixel register → WR with target = counter register, value i;
  - after the counter register → i+1; if i+1==NUM_PIXELS → SETTLE, else PIX.
- SETTLE: count SETTLE_CYCLES cycles, then RES_AR.
- RES_AR/RES_R: same handshake as the magic read, using the result address. On rvalid:
  - rresp≠0 → err 3;
  - else result ← rdata[23:0].
  - Go to FIN.
- FIN: done=1 for exactly one cycle, busy drops in the same cycle, return to IDLE.
- Valid outputs are never dropped before their ready. Payload is stable while valid is high.
- Exactly one outstanding transaction at a time; reads and writes never overlap.
- No timeout: a stalled slave stalls the block indefinitely.
- Reset mid-operation: return to IDLE next edge with all valids deasserted. The slave is expected to share the reset.
- Pixel index width is clog2(NUM_PIXELS+1); it never wraps within a job.

Test Plan:
- Happy path, NUM_PIXELS=4, slave model returning magic 0x47465550 and result 0x000007:
  - writes seen in order 0x0C,0x10,0x0C,0x10,…
  - counter data 0,1,2,3;
  - result=7, done pulses once, error=0.
- Slave returns magic 0x12345678 → no writes issued, done pulse, error=1, err_code=1.
- Slave raises awready 3 cycles before wready, then the reverse, then both together → each transaction issued exactly once, no duplicate beats.
- bresp=2'b10 on the third write → stop after that write, err_code=2, no result read issued, result unchanged.
- pix_valid gaps of 0–5 random cycles plus start pulses while busy → same transaction sequence as with no gaps; extra starts ignored.
- Assert reset while in WR with awvalid high → next cycle all valids 0, busy 0. A following start runs a clean full job.
